// File: rtl/vga_compositor.sv
// 800x600 raster generator and final layer mixer: publishes the raster position to the
// sprite layers, delays the timing flags to meet their pixels, and drives the VGA pins.
module vga_compositor #(
  parameter int          H_ACTIVE     = 800,
  parameter int          H_FP         = 56,
  parameter int          H_SYNC       = 120,
  parameter int          H_BP         = 64,
  parameter int          V_ACTIVE     = 600,
  parameter int          V_FP         = 37,
  parameter int          V_SYNC       = 6,
  parameter int          V_BP         = 23,
  parameter int          PIPE         = 2,
  parameter logic [23:0] BG_COLOR     = 24'h000020,
  parameter logic [23:0] BULLET_COLOR = 24'hFFFF00
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [24:0] ship_color,
  input  logic        bullet_pixel,
  output logic [11:0] display_col,
  output logic [10:0] display_row,
  output logic        frame_tick,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blank_n
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_ACT_END  = 12'(H_ACTIVE);
  localparam logic [11:0] H_SYNC_BEG = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] H_SYNC_END = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
  localparam logic [10:0] V_ACT_END  = 11'(V_ACTIVE);
  localparam logic [10:0] V_SYNC_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_END = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);

  logic [11:0] h_cnt;
  logic [10:0] v_cnt;
  logic        h_last, v_last;
  logic        act_p0, hs_p0, vs_p0;
  logic [PIPE-1:0] vld_p, hs_p, vs_p;
  logic [23:0] rgb_out;

  // Blanking forces black; inside the active area the bullet wins over an opaque ship.
  function automatic logic [23:0] mix_pixel(input logic act, input logic bullet,
                                            input logic [24:0] ship);
    if (!act)         return 24'h000000;
    else if (bullet)  return BULLET_COLOR;
    else if (ship[0]) return ship[24:1];
    else              return BG_COLOR;
  endfunction

  // Stage p0: raw timing flags decoded from the live counters.
  always_comb begin
    h_last = (h_cnt == H_LAST);
    v_last = (v_cnt == V_LAST);
    act_p0 = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
    hs_p0  = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
    vs_p0  = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      frame_tick  <= 1'b0;
      vld_p       <= '0;
      hs_p        <= '0;
      vs_p        <= '0;
      rgb_out     <= '0;
      vga_hs      <= 1'b0;
      vga_vs      <= 1'b0;
      vga_blank_n <= 1'b0;
    end else begin
      h_cnt <= h_last ? 12'd0 : h_cnt + 12'd1;
      if (h_last) v_cnt <= v_last ? 11'd0 : v_cnt + 11'd1;
      // Registered from the wrap condition so it is high while the counters read (0,0).
      frame_tick <= h_last && v_last;

      // Stages p1..pPIPE: flags travel with the layer pipeline.
      vld_p[0] <= act_p0;
      hs_p[0]  <= hs_p0;
      vs_p[0]  <= vs_p0;
      for (int i = 1; i < PIPE; i++) begin
        vld_p[i] <= vld_p[i-1];
        hs_p[i]  <= hs_p[i-1];
        vs_p[i]  <= vs_p[i-1];
      end

      // Output stage: colour and syncs share one register so the pins stay aligned.
      rgb_out     <= mix_pixel(vld_p[PIPE-1], bullet_pixel, ship_color);
      vga_hs      <= hs_p[PIPE-1];
      vga_vs      <= vs_p[PIPE-1];
      vga_blank_n <= vld_p[PIPE-1];
    end
  end

  assign display_col = h_cnt;
  assign display_row = v_cnt;
  assign vga_r       = rgb_out[23:16];
  assign vga_g       = rgb_out[15:8];
  assign vga_b       = rgb_out[7:0];

endmodule

// File: tb/tb_vga_compositor.sv
// Directed bench for vga_compositor on a shrunken raster, with a per-cycle scoreboard
// of the expected pin values built from an independent raster model.
module tb_vga_compositor;

  localparam int HA = 16, HF = 3, HS = 4, HB = 5;
  localparam int VA = 10, VF = 2, VS = 3, VB = 2;
  localparam int P  = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam logic [23:0] BG  = 24'h000020;
  localparam logic [23:0] BUL = 24'hFFFF00;

  logic        clock = 1'b0;
  logic        reset;
  logic [24:0] ship_color;
  logic        bullet_pixel;
  logic [11:0] display_col;
  logic [10:0] display_row;
  logic        frame_tick;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, vga_blank_n;

  vga_compositor #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .PIPE(P), .BG_COLOR(BG), .BULLET_COLOR(BUL)
  ) dut (
    .clock(clock), .reset(reset), .ship_color(ship_color), .bullet_pixel(bullet_pixel),
    .display_col(display_col), .display_row(display_row), .frame_tick(frame_tick),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n)
  );

  always #5 clock = ~clock;

  typedef struct packed {logic act; logic hs; logic vs;} flg_t;
  typedef struct packed {logic [23:0] rgb; logic hs; logic vs; logic blank;} pins_t;

  flg_t  flg_q[$];
  pins_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int mc = 0, mr = 0;
  int cyc = 0;
  int first_tick = -1;
  bit meas = 0;
  int hs_cnt = 0, vs_cnt = 0, bl_cnt = 0;
  logic prev_hs = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic reset_flags();
    flg_q.delete();
    for (int i = 0; i < P; i++) flg_q.push_back(flg_t'(3'b000));
  endtask

  // One clock: predict the pins for the next cycle, clock, then compare everything.
  task automatic step();
    flg_t  cur, f;
    pins_t e, got;
    bit    rst_edge;
    cur.act = (mc < HA) && (mr < VA);
    cur.hs  = (mc >= HA + HF) && (mc < HA + HF + HS);
    cur.vs  = (mr >= VA + VF) && (mr < VA + VF + VS);
    flg_q.push_back(cur);
    f = flg_q.pop_front();
    e.hs = f.hs;
    e.vs = f.vs;
    e.blank = f.act;
    if (!f.act)              e.rgb = 24'h0;
    else if (bullet_pixel)   e.rgb = BUL;
    else if (ship_color[0])  e.rgb = ship_color[24:1];
    else                     e.rgb = BG;
    rst_edge = !reset;
    if (rst_edge) e = '0;
    exp_q.push_back(e);

    @(posedge clock);
    #1;
    if (rst_edge) begin
      mc = 0; mr = 0;
      reset_flags();
    end else if (mc == HT - 1) begin
      mc = 0;
      mr = (mr == VT - 1) ? 0 : mr + 1;
    end else begin
      mc = mc + 1;
    end

    got = {vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n};
    e = exp_q.pop_front();
    check("pins", 64'(got), 64'(e));
    check("raster", {41'd0, display_row, display_col}, {41'd0, 11'(mr), 12'(mc)});
    check("frame_tick", 64'(frame_tick), 64'(!rst_edge && mc == 0 && mr == 0));
    if (!rst_edge && vga_hs && !prev_hs)
      check("hs_start_col", 64'(display_col), 64'((HA + HF + P + 1) % HT));
    prev_hs = vga_hs;

    cyc++;
    if (frame_tick && first_tick < 0) first_tick = cyc;
    if (meas) begin
      hs_cnt += int'(vga_hs);
      vs_cnt += int'(vga_vs);
      bl_cnt += int'(vga_blank_n);
    end
  endtask

  task automatic run_to(input int c, input int r);
    int n = 0;
    while (!(mc == c && mr == r) && n < 2 * FRAME) begin
      step();
      n++;
    end
    check("run_to", 64'(mc == c && mr == r), 64'd1);
  endtask

  initial begin
    reset_flags();
    reset = 1'b0;
    ship_color = {24'hABCDEF, 1'b1};
    bullet_pixel = 1'b1;

    // Reset held for 5 clocks: everything reads zero despite live layer inputs.
    repeat (5) step();
    check("reset_rgb", {40'd0, vga_r, vga_g, vga_b}, 64'd0);

    // Release and run two frames; the second frame has random layer inputs and is measured.
    reset = 1'b1;
    ship_color = '0;
    bullet_pixel = 1'b0;
    cyc = 0;
    first_tick = -1;
    step();
    check("release_col", 64'(display_col), 64'd1);
    while (cyc < FRAME) step();
    check("first_tick", 64'(first_tick), 64'(FRAME));
    meas = 1;
    while (cyc < 2 * FRAME) begin
      ship_color = 25'($urandom);
      bullet_pixel = ($urandom_range(0, 3) == 0);
      step();
    end
    meas = 0;
    check("hs_per_frame", 64'(hs_cnt), 64'(HS * VT));
    check("vs_per_frame", 64'(vs_cnt), 64'(VS * HT));
    check("blank_per_frame", 64'(bl_cnt), 64'(HA * VA));

    // Latency: a single-cycle opaque red ship pixel lands PIPE+1 clocks after (5,3).
    ship_color = '0;
    bullet_pixel = 1'b0;
    run_to(5, 3);
    repeat (P) step();
    ship_color = {24'hFF0000, 1'b1};
    step();
    ship_color = '0;
    check("lat_rgb", {40'd0, vga_r, vga_g, vga_b}, 64'h00FF0000);
    check("lat_col", 64'(display_col), 64'(5 + P + 1));
    step();
    check("lat_neighbour", {40'd0, vga_r, vga_g, vga_b}, 64'(BG));

    // Priority: bullet over opaque ship, transparent ship shows background.
    run_to(2, 4);
    repeat (P) step();
    ship_color = {24'h00FF00, 1'b1};
    bullet_pixel = 1'b1;
    step();
    check("prio_bullet", {40'd0, vga_r, vga_g, vga_b}, 64'(BUL));
    ship_color = {24'h808000, 1'b0};
    bullet_pixel = 1'b0;
    step();
    check("prio_transparent", {40'd0, vga_r, vga_g, vga_b}, 64'(BG));

    // Horizontal blanking masks both layers.
    ship_color = '0;
    run_to(HA, 5);
    repeat (P) step();
    ship_color = {24'h12AB34, 1'b1};
    bullet_pixel = 1'b1;
    repeat (4) begin
      step();
      check("blank_rgb", {39'd0, vga_r, vga_g, vga_b, vga_blank_n}, 64'd0);
    end
    ship_color = '0;
    bullet_pixel = 1'b0;

    // Mid-frame reset pulse, then a clean restart for more than a frame.
    run_to(3, 6);
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("midreset_raster", {41'd0, display_row, display_col}, 64'd0);
    check("midreset_pins", {37'd0, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n}, 64'd0);
    repeat (FRAME + 10) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_compositor.md
# vga_compositor

Generates the 800x600 display raster and drives the VGA output pins. Publishes the current raster position (`display_col`, `display_row`) to the sprite layers and consumes the ship's registered pixel (`ship_color`) plus a one-bit bullet pixel. It priority-mixes those layers over a flat background, and re-aligns sync and blank with the layer pipeline latency. It sits directly downstream of the ship layer and is the last stage before the DAC.

## Interface

Parameters:
- `H_ACTIVE`, 800: visible pixels per line
- `H_FP`, 56: horizontal front porch (clocks)
- `H_SYNC`, 120: horizontal sync width
- `H_BP`, 64: horizontal back porch
- `V_ACTIVE`, 600: visible lines
- `V_FP`, 37: vertical front porch (lines)
- `V_SYNC`, 6: vertical sync width
- `V_BP`, 23: vertical back porch
- `PIPE`, 2: clocks from `display_col`/`display_row` to the matching `ship_color`/`bullet_pixel`; legal range 1..7
- `BG_COLOR`, 24'h000020: background RGB
- `BULLET_COLOR`, 24'hFFFF00: bullet RGB

Ports:
- `clock` in 1: pixel clock (50 MHz for 800x600@72)
- `reset` in 1: synchronous, active-low; `reset==0` at a rising edge resets the block
- `ship_color` in 25: `[24:1]` = RGB (R=`[24:17]`), `[0]` = opaque flag
- `bullet_pixel` in 1: 1 = bullet covers this pixel
- `display_col` out 12: current horizontal counter, 0..H_TOTAL-1
- `display_row` out 11: current vertical counter, 0..V_TOTAL-1
- `frame_tick` out 1: one-clock pulse at start of each frame
- `vga_r`, `vga_g`, `vga_b` out 8 each: pixel colour
- `vga_hs`, `vga_vs` out 1 each: syncs, active-high
- `vga_blank_n` out 1: 1 = active video

## Operation

- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 1040.
- V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP = 666.
- `h_cnt` increments every clock. It wraps H_TOTAL-1 -> 0.
- `v_cnt` increments when `h_cnt` wraps. It wraps V_TOTAL-1 -> 0 only when `h_cnt` also wraps.
- `display_col`/`display_row` are the counters themselves (registered). Values >= H_ACTIVE/V_ACTIVE are blanking, and the layers must output transparent there.
- Raw timing signals, computed from the counters in cycle t:
  - `act` = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE)
  - `hs` = H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC
  - `vs` = V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC
- `act`, `hs` and `vs` pass through a PIPE-deep shift register, so they are available alongside the layer inputs.
- Output register, loaded every clock with the delayed `act`:
  - if act=0: RGB = 0
  - else if `bullet_pixel`: RGB = BULLET_COLOR
  - else if `ship_color[0]`: RGB = `ship_color[24:1]`
  - else: RGB = BG_COLOR
- `vga_hs`, `vga_vs` and `vga_blank_n` are registered in the same stage, so all pins are mutually aligned.
- `frame_tick` is registered. It is 1 exactly in the cycle where `display_col==0` and `display_row==0`.

## Timing

- Reset (`reset==0` at an edge) forces:
  - `h_cnt`/`v_cnt`, and hence `display_col`/`display_row`, to 0
  - all delay-line bits to 0
  - RGB, `vga_hs`, `vga_vs`, `vga_blank_n` to 0
  - `frame_tick` to 0
- First edge after reset is released:
  - counters go to (1,0)
  - `frame_tick` stays 0; the first tick occurs at the next frame wrap
- A pixel at counter value (c,r) in cycle t appears on the VGA pins in cycle t+PIPE+1. Sync edges shift by the same amount.
- `ship_color`/`bullet_pixel` are sampled only at edge t+PIPE. Values in other cycles have no effect.
- Reset mid-frame takes effect at the next edge regardless of counter state. Stale layer inputs are ignored because the delayed `act` is 0.
- Line wrap: `display_col` goes 1039 -> 0 and `display_row` increments in the same edge. At row 665 both counters wrap to 0 together.

## Test plan

- **Reset and release:** hold reset low 5 clocks -> all outputs 0. Release -> `display_col` counts 0,1,2…, and `frame_tick` first pulses 1040*666 clocks after the first (0,0).
- **Sync geometry:** run one frame ->
  - `vga_hs` high for exactly 120 clocks, first high at `display_col`=856+PIPE+1 (mod 1040)
  - `vga_vs` high for 6*1040 clocks, starting line 637
  - `vga_blank_n` high 800 clocks per line on 600 lines
- **Latency:** drive `ship_color`={24'hFF0000,1} only in the cycle PIPE after `display_col`=100,row=50 -> `vga_r`=FF, g=b=0 exactly PIPE+1 clocks after (100,50); neighbours show BG_COLOR.
- **Priority:** `bullet_pixel`=1 with opaque ship -> 24'hFFFF00. Ship `[0]`=0 with colour 24'h808000 -> BG_COLOR.
- **Blanking masks layers:** ship opaque and bullet=1 while `display_col`>=800 -> RGB 0, `vga_blank_n`=0.
- **Mid-frame reset:** pulse reset low for 1 clock at row 300 -> next edge counters 0, outputs 0; timing restarts cleanly.
